// File: rtl/mod_add_acc.sv
// rtl/mod_add_acc.sv - streaming modular accumulator, one reduced sum per frame
module mod_add_acc #(
  parameter int K  = 54,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [K-1:0]  q,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [K-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [K-1:0]  out_data,
  output logic [CW-1:0] out_count
);

  logic [K-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [K-1:0]  out_data_q, out_data_d;
  logic [CW-1:0] out_count_q, out_count_d;

  logic          acc_in;
  logic [K:0]    sum_w;
  logic [K:0]    diff_w;
  logic [K:0]    red_w;
  logic [CW-1:0] cnt_n;

  assign in_ready = !out_valid_q || out_ready;
  assign acc_in   = in_valid && in_ready;

  // Both operands are below q, so the K+1 bit sum is below 2q and one
  // conditional subtraction fully reduces it.
  assign sum_w  = {1'b0, acc_q} + {1'b0, in_data};
  assign diff_w = sum_w - {1'b0, q};
  assign red_w  = (sum_w >= {1'b0, q}) ? diff_w : sum_w;
  assign cnt_n  = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (acc_in) begin
      if (in_last) begin
        out_data_d  = red_w[K-1:0];
        out_count_d = cnt_n;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = red_w[K-1:0];
        cnt_d = cnt_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

  // Simulation guards for the operand preconditions and the no-wrap property.
  a_in_range: assert property (@(posedge clk) disable iff (rst)
    acc_in |-> (in_data < q));
  a_q_min: assert property (@(posedge clk) disable iff (rst)
    q >= K'(2));
  a_q_stable: assert property (@(posedge clk) disable iff (rst)
    (cnt_q != '0) |-> $stable(q));
  a_reduced: assert property (@(posedge clk) disable iff (rst)
    acc_in |-> (red_w[K] == 1'b0));

endmodule

// File: tb/tb_mod_add_acc.sv
// tb/tb_mod_add_acc.sv - randomized self-checking bench for mod_add_acc
module tb_mod_add_acc;
  localparam int K  = 8;
  localparam int CW = 16;
  localparam int QV = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [K-1:0]  q;
  logic          in_valid;
  logic          in_ready;
  logic [K-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [K-1:0]  out_data;
  logic [CW-1:0] out_count;
  logic          rdy_fixed, rand_rdy, rnd_rdy;

  assign out_ready = rand_rdy ? rnd_rdy : rdy_fixed;

  mod_add_acc #(.K(K), .CW(CW)) u_dut (
    .clk(clk), .rst(rst), .q(q),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );

  // Wide-modulus instance
  logic [53:0] q54, in_data54, out_data54;
  logic        in_valid54, in_ready54, in_last54, out_valid54;
  logic        out_ready54;
  logic [15:0] out_count54;

  mod_add_acc #(.K(54), .CW(16)) u_dut54 (
    .clk(clk), .rst(rst), .q(q54),
    .in_valid(in_valid54), .in_ready(in_ready54), .in_data(in_data54), .in_last(in_last54),
    .out_valid(out_valid54), .out_ready(out_ready54), .out_data(out_data54), .out_count(out_count54)
  );

  // Narrow beat-counter instance
  logic [7:0] in_data2, out_data2;
  logic       in_valid2, in_ready2, in_last2, out_valid2;
  logic       out_ready2;
  logic [1:0] out_count2;

  mod_add_acc #(.K(8), .CW(2)) u_dut2 (
    .clk(clk), .rst(rst), .q(q),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_last(in_last2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_count(out_count2)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int obs_d[$];
  int obs_c[$];
  int obs_t[$];
  int exp_d[$];
  int exp_c[$];

  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    #1;
    rnd_rdy = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      obs_d.push_back(int'(out_data));
      obs_c.push_back(int'(out_count));
      obs_t.push_back(cyc);
    end
  end

  // Reference: a frame result is the plain sum mod q and the saturated length.
  task automatic model_frame(input int vals[$], input int cmax);
    int sum;
    sum = 0;
    foreach (vals[i]) sum = sum + vals[i];
    exp_d.push_back(sum % QV);
    exp_c.push_back((vals.size() > cmax) ? cmax : vals.size());
  endtask

  task automatic clear_queues();
    obs_d.delete(); obs_c.delete(); obs_t.delete();
    exp_d.delete(); exp_c.delete();
  endtask

  // Offers one beat and holds it until accepted; returns stall cycles.
  task automatic send_beat(input int d, input bit last, output int waited);
    in_valid = 1'b1;
    in_data  = K'(d);
    in_last  = last;
    waited   = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready || waited >= 200) break;
      waited++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = K'($urandom);
    in_last  = 1'($urandom);
  endtask

  task automatic wait_results(input int n, output bit ok);
    int t;
    t = 0;
    while (obs_d.size() < n && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    ok = (obs_d.size() == n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1; in_data = 8'd5; in_last = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    tests++; if (out_data !== 8'd0) begin fails++; $display("FAIL reset_out_data got %0d want 0", out_data); end
    tests++; if (out_count !== 16'd0) begin fails++; $display("FAIL reset_out_count got %0d want 0", out_count); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    tests++; if (out_valid54 !== 1'b0 || out_valid2 !== 1'b0) begin fails++; $display("FAIL reset_aux_valid got %0b/%0b want 0/0", out_valid54, out_valid2); end
  endtask

  task automatic test_basic();
    int w;
    clear_queues();
    rdy_fixed = 1'b1;
    send_beat(5, 1'b0, w);
    send_beat(9, 1'b0, w);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_midframe_valid got %0b want 0", out_valid); end
    send_beat(10, 1'b1, w);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_latency_valid got %0b want 1", out_valid); end
    tests++; if (out_data !== 8'd7) begin fails++; $display("FAIL basic_data got %0d want 7", out_data); end
    tests++; if (out_count !== 16'd3) begin fails++; $display("FAIL basic_count got %0d want 3", out_count); end
    @(posedge clk);
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_one_cycle got %0b want 0", out_valid); end
    tests++; if (out_data !== 8'd7 || out_count !== 16'd3) begin fails++; $display("FAIL basic_hold got %0d/%0d want 7/3", out_data, out_count); end
  endtask

  task automatic test_wrap();
    int w;
    bit ok;
    clear_queues();
    rdy_fixed = 1'b1;
    model_frame('{16, 16, 16}, 65535);
    model_frame('{0}, 65535);
    send_beat(16, 1'b0, w); send_beat(16, 1'b0, w); send_beat(16, 1'b1, w);
    send_beat(0, 1'b1, w);
    wait_results(2, ok);
    tests++; if (!ok) begin fails++; $display("FAIL wrap_count_results got %0d want 2", obs_d.size()); end
    else begin
      tests++; if (obs_d[0] !== 14 || obs_c[0] !== 3) begin fails++; $display("FAIL wrap_frame0 got %0d/%0d want 14/3", obs_d[0], obs_c[0]); end
      tests++; if (obs_d[1] !== exp_d[1] || obs_c[1] !== exp_c[1]) begin fails++; $display("FAIL wrap_frame1 got %0d/%0d want %0d/%0d", obs_d[1], obs_c[1], exp_d[1], exp_c[1]); end
    end
  endtask

  task automatic test_backpressure();
    int w;
    bit ok;
    clear_queues();
    rdy_fixed = 1'b0;
    send_beat(3, 1'b1, w);
    in_valid = 1'b1; in_data = 8'd4; in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'd3) begin
        fails++; $display("FAIL bp_stall[%0d] got rdy=%0b v=%0b d=%0d want 0/1/3", i, in_ready, out_valid, out_data);
      end
    end
    rdy_fixed = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_pop_valid got %0b want 0", out_valid); end
    send_beat(5, 1'b1, w);
    tests++; if (w !== 0) begin fails++; $display("FAIL bp_second_wait got %0d want 0", w); end
    wait_results(2, ok);
    tests++; if (!ok) begin fails++; $display("FAIL bp_results got %0d want 2", obs_d.size()); end
    else begin
      tests++; if (obs_d[0] !== 3 || obs_c[0] !== 1) begin fails++; $display("FAIL bp_res0 got %0d/%0d want 3/1", obs_d[0], obs_c[0]); end
      tests++; if (obs_d[1] !== 9 || obs_c[1] !== 2) begin fails++; $display("FAIL bp_res1 got %0d/%0d want 9/2", obs_d[1], obs_c[1]); end
    end
  endtask

  task automatic test_back_to_back();
    int w, stalls;
    bit ok;
    clear_queues();
    rdy_fixed = 1'b1;
    stalls = 0;
    for (int v = 1; v <= 16; v++) begin
      model_frame('{v}, 65535);
      send_beat(v, 1'b1, w);
      stalls += w;
    end
    wait_results(16, ok);
    tests++; if (stalls !== 0) begin fails++; $display("FAIL b2b_stalls got %0d want 0", stalls); end
    tests++; if (!ok) begin fails++; $display("FAIL b2b_results got %0d want 16", obs_d.size()); end
    else begin
      for (int i = 0; i < 16; i++) begin
        tests++; if (obs_d[i] !== exp_d[i] || obs_c[i] !== exp_c[i]) begin
          fails++; $display("FAIL b2b_res[%0d] got %0d/%0d want %0d/%0d", i, obs_d[i], obs_c[i], exp_d[i], exp_c[i]);
        end
      end
      tests++; if (obs_t[15] - obs_t[0] !== 15) begin fails++; $display("FAIL b2b_bubbles got span %0d want 15", obs_t[15] - obs_t[0]); end
    end
  endtask

  task automatic test_random();
    int w, len, bad;
    int vals[$];
    bit ok;
    clear_queues();
    rand_rdy = 1'b1;
    bad = 0;
    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(1, 6);
      vals.delete();
      for (int b = 0; b < len; b++) vals.push_back($urandom_range(0, QV - 1));
      model_frame(vals, 65535);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        send_beat(vals[b], (b == len - 1), w);
        if (w >= 200) bad++;
      end
    end
    rand_rdy = 1'b0;
    rdy_fixed = 1'b1;
    wait_results(30, ok);
    tests++; if (bad !== 0) begin fails++; $display("FAIL rand_timeouts got %0d want 0", bad); end
    tests++; if (!ok) begin fails++; $display("FAIL rand_results got %0d want 30", obs_d.size()); end
    else begin
      for (int i = 0; i < 30; i++) begin
        tests++; if (obs_d[i] !== exp_d[i] || obs_c[i] !== exp_c[i]) begin
          fails++; $display("FAIL rand_res[%0d] got %0d/%0d want %0d/%0d", i, obs_d[i], obs_c[i], exp_d[i], exp_c[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int w;
    bit ok;
    clear_queues();
    rdy_fixed = 1'b1;
    send_beat(7, 1'b0, w);
    send_beat(8, 1'b0, w);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tests++; if (out_valid !== 1'b0 || out_data !== 8'd0) begin fails++; $display("FAIL rstmid_out got v=%0b d=%0d want 0/0", out_valid, out_data); end
    send_beat(2, 1'b1, w);
    wait_results(1, ok);
    tests++; if (!ok) begin fails++; $display("FAIL rstmid_results got %0d want 1", obs_d.size()); end
    else begin
      tests++; if (obs_d[0] !== 2 || obs_c[0] !== 1) begin fails++; $display("FAIL rstmid_res got %0d/%0d want 2/1", obs_d[0], obs_c[0]); end
    end
  endtask

  task automatic test_wide();
    logic [63:0] s64;
    logic [53:0] exp54;
    in_valid54 = 1'b1; in_data54 = q54 - 54'd1; in_last54 = 1'b0;
    @(posedge clk);
    #1;
    in_last54 = 1'b1;
    @(posedge clk);
    #1;
    in_valid54 = 1'b0;
    s64 = 64'(q54 - 54'd1) * 64'd2;
    exp54 = 54'(s64 % 64'(q54));
    tests++; if (out_valid54 !== 1'b1 || out_data54 !== exp54 || out_count54 !== 16'd2) begin
      fails++; $display("FAIL wide_res got v=%0b %0h/%0d want 1 %0h/2", out_valid54, out_data54, out_count54, exp54);
    end
    in_valid2 = 1'b1; in_data2 = 8'd1; in_last2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_last2 = (i == 4);
      @(posedge clk);
      #1;
    end
    in_valid2 = 1'b0;
    tests++; if (out_valid2 !== 1'b1 || out_data2 !== 8'd5 || out_count2 !== 2'd3) begin
      fails++; $display("FAIL satcnt_res got v=%0b %0d/%0d want 1 5/3", out_valid2, out_data2, out_count2);
    end
  endtask

  initial begin
    q = K'(QV);
    q54 = 54'h3F_FFFF_FFFF_FFDF;
    rdy_fixed = 1'b1; rand_rdy = 1'b0; rnd_rdy = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    in_valid54 = 1'b0; in_data54 = '0; in_last54 = 1'b0; out_ready54 = 1'b1;
    in_valid2 = 1'b0; in_data2 = '0; in_last2 = 1'b0; out_ready2 = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached at time %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
